// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio playback path: the play controller,
// the PWM output stage and the filter engine all import this package.
package audio_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int DEF_PWM_PERIOD = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        PRIME  = 2'd2,
        PLAY   = 2'd3
    } play_state_t;

endpackage

// File: rtl/audio_frame_timer.sv
// PWM frame counter: counts 0..PWM_PERIOD-1 while enabled and flags the
// sample-load cycle (cnt==1) and the last clock of each frame.
module audio_frame_timer
    import audio_pkg::*;
#(
    parameter  int PWM_PERIOD = DEF_PWM_PERIOD,
    localparam int CNT_W      = $clog2(PWM_PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             load_strobe,
    output logic             sample_tick
);

    logic last;

    assign last = (cnt == CNT_W'(PWM_PERIOD - 1));

    // NOTE: sequential state is assigned with <= only, so every register samples
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // A clear in the same cycle suppresses both strobes, so a stop never emits a tick.
    assign load_strobe = en & ~clr & (cnt == CNT_W'(1));
    assign sample_tick = en & ~clr & last;

endmodule

// File: rtl/audio_play_ctrl.sv
// Playback sequencer: optional filter pass, one priming cycle for RAM latency,
// then one sample per PWM frame presented as the PWM threshold.
module audio_play_ctrl
    import audio_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                PWM_PERIOD   = DEF_PWM_PERIOD,
    parameter logic [ADDR_W-1:0] LAST_ADDR    = '1,
    parameter int                FILT_TIMEOUT = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_start,
    input  logic                btn_stop,
    input  logic                sw_play,
    input  logic                sw_loop,
    output logic                filt_start,
    input  logic                filt_done,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [SAMPLE_W-1:0] ram_org_din,
    input  logic [SAMPLE_W-1:0] ram_filt_din,
    output logic [SAMPLE_W-1:0] pcm_thresh,
    output logic                sample_tick,
    output logic                busy,
    output logic [1:0]          state_o,
    output logic                filt_err
);

    localparam int WAIT_W = (FILT_TIMEOUT > 1) ? $clog2(FILT_TIMEOUT) : 1;
    localparam int CNT_W  = $clog2(PWM_PERIOD);

    play_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              filt_start_d, err_set, err_clr;
    logic              stop, run_end, frame_tick, load_strobe;
    logic              timer_clr, timer_en;
    logic [CNT_W-1:0]  unused_frame_cnt;

    assign stop      = btn_stop & (state_q != IDLE);
    assign timer_en  = (state_q == PLAY);
    assign timer_clr = (state_q != PLAY) | btn_stop;
    assign run_end   = frame_tick & (ram_addr == LAST_ADDR) & ~sw_loop;

    audio_frame_timer #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_frame_timer (
        .clk         (clk),
        .rst         (rst),
        .clr         (timer_clr),
        .en          (timer_en),
        .cnt         (unused_frame_cnt),
        .load_strobe (load_strobe),
        .sample_tick (frame_tick)
    );

    // NOTE: every always_comb output gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        filt_start_d = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_start) begin
                    if (sw_play) begin
                        state_d      = FILTER;
                        filt_start_d = 1'b1;
                        err_clr      = 1'b1;
                    end else begin
                        state_d = PRIME;
                    end
                end
            end
            FILTER: begin
                if (btn_stop) begin
                    state_d = IDLE;
                end else if (filt_done) begin
                    state_d = PRIME;
                end else if (wait_cnt == WAIT_W'(FILT_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end
            end
            PRIME: begin
                state_d = btn_stop ? IDLE : PLAY;
            end
            PLAY: begin
                if (btn_stop || run_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: asynchronous reset asserts immediately; release is expected to be
    // synchronised to clk upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            filt_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            filt_start <= filt_start_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            ram_addr   <= '0;
            pcm_thresh <= '0;
            filt_err   <= 1'b0;
        end else begin
            wait_cnt <= (state_q == FILTER) ? wait_cnt + WAIT_W'(1) : '0;

            // Address is parked at 0 outside PLAY so PRIME always fetches sample 0.
            if (state_q != PLAY || btn_stop) begin
                ram_addr <= '0;
            end else if (frame_tick) begin
                ram_addr <= (ram_addr == LAST_ADDR) ? '0 : ram_addr + ADDR_W'(1);
            end

            if (stop || run_end) begin
                pcm_thresh <= '0;
            end else if (load_strobe) begin
                pcm_thresh <= sw_play ? ram_filt_din : ram_org_din;
            end

            if (err_clr) begin
                filt_err <= 1'b0;
            end else if (err_set) begin
                filt_err <= 1'b1;
            end
        end
    end

    assign sample_tick = frame_tick;
    assign busy        = (state_q != IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Self-checking bench for audio_play_ctrl: a table of playback runs, directed
// corner-case sequences and randomized runs checked against a per-frame model.
module tb_audio_play_ctrl;
    import audio_pkg::*;

    localparam int              ADDR_W       = 16;
    localparam int              PWM_PERIOD   = 8;
    localparam int              FILT_TIMEOUT = 24;
    localparam logic [15:0]     LAST_ADDR    = 16'd3;
    localparam int              NADDR        = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start, btn_stop, sw_play, sw_loop, filt_done;
    logic        filt_start, sample_tick, busy, filt_err;
    logic [15:0] ram_addr, ram_org_din, ram_filt_din, pcm_thresh;
    logic [1:0]  state_o;

    logic [15:0] org_mem  [NADDR];
    logic [15:0] filt_mem [NADDR];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       play;
        logic       loop;
        int         filt_delay;
        int         frames;
        logic       noise;
        logic [1:0] exp_end;
    } vec_t;

    vec_t vecs [5];

    audio_play_ctrl #(
        .ADDR_W       (ADDR_W),
        .PWM_PERIOD   (PWM_PERIOD),
        .LAST_ADDR    (LAST_ADDR),
        .FILT_TIMEOUT (FILT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .sw_play      (sw_play),
        .sw_loop      (sw_loop),
        .filt_start   (filt_start),
        .filt_done    (filt_done),
        .ram_addr     (ram_addr),
        .ram_org_din  (ram_org_din),
        .ram_filt_din (ram_filt_din),
        .pcm_thresh   (pcm_thresh),
        .sample_tick  (sample_tick),
        .busy         (busy),
        .state_o      (state_o),
        .filt_err     (filt_err)
    );

    always #5 clk = ~clk;

    // Sample RAMs with one cycle of read latency.
    always @(posedge clk) begin
        ram_org_din  <= org_mem[ram_addr[1:0]];
        ram_filt_din <= filt_mem[ram_addr[1:0]];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected threshold for the idx-th played frame: frames walk addresses 0..LAST_ADDR.
    function automatic logic [15:0] model_thresh(input int idx, input logic play);
        return play ? filt_mem[idx % NADDR] : org_mem[idx % NADDR];
    endfunction

    task automatic check_idle(input string name);
        check({name, "_state"}, 32'(state_o), 32'(IDLE));
        check({name, "_addr"}, 32'(ram_addr), 0);
        check({name, "_thresh"}, 32'(pcm_thresh), 0);
        check({name, "_busy"}, 32'(busy), 0);
    endtask

    // Start a run and leave the bench at the first PLAY cycle (cnt==0).
    task automatic start_run(input logic play, input int filt_delay);
        sw_play   = play;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        if (play) begin
            check("filt_entry_state", 32'(state_o), 32'(FILTER));
            check("filt_start_pulse", 32'(filt_start), 1);
            check("filt_err_cleared", 32'(filt_err), 0);
            for (int i = 1; i < filt_delay; i++) begin
                step();
                if (i == 1) check("filt_start_single", 32'(filt_start), 0);
            end
            filt_done = 1'b1;
            step();
            filt_done = 1'b0;
        end
        check("prime_state", 32'(state_o), 32'(PRIME));
        check("prime_addr", 32'(ram_addr), 0);
        check("prime_filt_start_low", 32'(filt_start), 0);
        step();
        check("play_state", 32'(state_o), 32'(PLAY));
    endtask

    // Advance to the next observed sample_tick; optional ignored-input noise.
    task automatic wait_tick(input int exp_steps, input logic noise);
        int steps = 0;
        do begin
            if (noise) begin
                btn_start = ($urandom_range(0, 7) == 0);
                filt_done = ($urandom_range(0, 7) == 0);
            end
            step();
            steps++;
        end while (!sample_tick && steps < 3 * PWM_PERIOD);
        btn_start = 1'b0;
        filt_done = 1'b0;
        check("tick_spacing", 32'(steps), 32'(exp_steps));
    endtask

    task automatic check_frame(input int idx, input logic play);
        check("frame_addr", 32'(ram_addr), 32'(idx % NADDR));
        check("frame_thresh", 32'(pcm_thresh), 32'(model_thresh(idx, play)));
        check("frame_busy", 32'(busy), 1);
    endtask

    task automatic run_vec(input vec_t v, input logic toggle);
        logic cur_play;
        cur_play = v.play;
        sw_loop  = v.loop;
        start_run(v.play, v.filt_delay);
        for (int f = 0; f < v.frames; f++) begin
            wait_tick((f == 0) ? PWM_PERIOD - 1 : PWM_PERIOD, v.noise);
            check_frame(f, cur_play);
            if (toggle && f < v.frames - 1) begin
                cur_play = 1'($urandom_range(0, 1));
                sw_play  = cur_play;
            end
        end
        step();
        check("end_state", 32'(state_o), 32'(v.exp_end));
        if (v.exp_end == IDLE) begin
            check_idle("run_end");
        end else begin
            check("run_cont_addr", 32'(ram_addr), 32'(v.frames % NADDR));
            btn_stop = 1'b1;
            step();
            btn_stop = 1'b0;
            check_idle("run_stop");
        end
    endtask

    initial begin
        int   fcyc;
        vec_t rv;

        rst = 1'b1;
        {btn_start, btn_stop, sw_play, sw_loop, filt_done} = '0;
        for (int a = 0; a < NADDR; a++) begin
            org_mem[a]  = 16'(16'h0100 * (a + 1));
            filt_mem[a] = 16'(16'hA000 + 16'h0011 * a);
        end

        vecs[0] = '{1'b0, 1'b0, 1,  4, 1'b0, IDLE};
        vecs[1] = '{1'b1, 1'b0, 20, 4, 1'b0, IDLE};
        vecs[2] = '{1'b0, 1'b1, 1,  6, 1'b1, PLAY};
        vecs[3] = '{1'b1, 1'b1, 1,  5, 1'b1, PLAY};
        vecs[4] = '{1'b1, 1'b0, 5,  2, 1'b1, PLAY};

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_filt_start", 32'(filt_start), 0);
        check("reset_tick", 32'(sample_tick), 0);
        check("reset_filt_err", 32'(filt_err), 0);
        rst = 1'b0;
        step();
        check_idle("idle_hold");

        // Start-to-threshold latency with original data.
        sw_play = 1'b0;
        sw_loop = 1'b0;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("lat_prime", 32'(state_o), 32'(PRIME));
        step();
        check("lat_play", 32'(state_o), 32'(PLAY));
        step();
        check("lat_cnt1_old", 32'(pcm_thresh), 0);
        step();
        check("lat_cnt2_new", 32'(pcm_thresh), 32'h0100);
        btn_stop = 1'b1;
        step();
        btn_stop = 1'b0;
        check_idle("lat_stop");

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

        // Filter timeout, ignored late filt_done, error cleared by next start.
        sw_play = 1'b1;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        fcyc = 0;
        while (state_o == 2'(FILTER) && fcyc < 4 * FILT_TIMEOUT) begin
            fcyc++;
            step();
        end
        check("timeout_cycles", 32'(fcyc), 32'(FILT_TIMEOUT));
        check("timeout_state", 32'(state_o), 32'(IDLE));
        check("timeout_err", 32'(filt_err), 1);
        filt_done = 1'b1;
        step();
        filt_done = 1'b0;
        check("idle_done_ignored", 32'(state_o), 32'(IDLE));
        check("err_sticky", 32'(filt_err), 1);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("restart_err_clr", 32'(filt_err), 0);
        check("restart_state", 32'(state_o), 32'(FILTER));
        btn_stop  = 1'b1;
        filt_done = 1'b1;
        step();
        btn_stop  = 1'b0;
        filt_done = 1'b0;
        check("stop_beats_done", 32'(state_o), 32'(IDLE));
        filt_done = 1'b1;
        step();
        filt_done = 1'b0;
        check("late_done_ignored", 32'(state_o), 32'(IDLE));

        // Stop on the last clock of the frame at address 2.
        sw_loop = 1'b1;
        start_run(1'b0, 1);
        for (int f = 0; f < 3; f++) begin
            wait_tick((f == 0) ? PWM_PERIOD - 1 : PWM_PERIOD, 1'b0);
            check_frame(f, 1'b0);
        end
        btn_stop = 1'b1;
        #1;
        check("stop_no_tick", 32'(sample_tick), 0);
        step();
        btn_stop = 1'b0;
        check_idle("stop_cnt7");

        // Simultaneous start+stop in PLAY.
        start_run(1'b0, 1);
        wait_tick(PWM_PERIOD - 1, 1'b0);
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        step();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        check_idle("start_stop");

        // Start alone while playing leaves address and frame timing untouched.
        start_run(1'b0, 1);
        wait_tick(PWM_PERIOD - 1, 1'b0);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("busy_start_state", 32'(state_o), 32'(PLAY));
        check("busy_start_addr", 32'(ram_addr), 1);
        wait_tick(PWM_PERIOD - 1, 1'b0);
        check_frame(1, 1'b0);
        btn_stop = 1'b1;
        step();
        btn_stop = 1'b0;

        // Randomized runs: random RAM contents, switches, filter delay and noise.
        for (int r = 0; r < 25; r++) begin
            for (int a = 0; a < NADDR; a++) begin
                org_mem[a]  = 16'($urandom);
                filt_mem[a] = 16'($urandom);
            end
            rv.play       = 1'($urandom_range(0, 1));
            rv.loop       = 1'($urandom_range(0, 1));
            rv.filt_delay = $urandom_range(1, 20);
            rv.frames     = rv.loop ? $urandom_range(1, 9) : $urandom_range(1, 4);
            rv.noise      = 1'b1;
            rv.exp_end    = (!rv.loop && rv.frames == NADDR) ? IDLE : PLAY;
            run_vec(rv, 1'b1);
        end

        // Asynchronous reset mid-PLAY at address 2, cnt 5.
        sw_play = 1'b0;
        sw_loop = 1'b1;
        start_run(1'b0, 1);
        wait_tick(PWM_PERIOD - 1, 1'b0);
        wait_tick(PWM_PERIOD, 1'b0);
        repeat (6) step();
        check("pre_reset_addr", 32'(ram_addr), 2);
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_tick", 32'(sample_tick), 0);
        check("async_rst_fs", 32'(filt_start), 0);
        check("async_rst_err", 32'(filt_err), 0);
        step();
        rst = 1'b0;
        step();
        check_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/audio_play_ctrl.md
Name: audio_play_ctrl

Overview:
- Sequences one complete audio playback run.
- On a start command it optionally launches the filter engine over the sample RAM and waits for it to finish.
- It then walks the sample RAM at one sample per PWM period, presenting the selected sample (original or filtered) as the PWM threshold to the PWM output stage.
- It sits between the user switches/buttons, the filter engine, the dual sample RAMs and the PWM stage.

Parameters:
- ADDR_W, 16, sample RAM address width.
- PWM_PERIOD, 512, clocks per sample (one PWM frame); must be ≥ 4.
- LAST_ADDR, 16'hFFFF, last sample address played (inclusive).
- FILT_TIMEOUT, 1048576, max clocks to wait for filt_done before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  single-cycle start pulse, already synchronised.
- btn_stop  in  1  single-cycle stop pulse, already synchronised.
- sw_play  in  1  1 = play filtered data (filter pass first), 0 = play original data (no filter pass).
- sw_loop  in  1  1 = wrap to address 0 after LAST_ADDR, 0 = stop.
- filt_start  out  1  single-cycle pulse launching the filter engine.
- filt_done  in  1  single-cycle pulse from the filter engine.
- ram_addr  out  ADDR_W  read address to both sample RAMs (1-cycle read latency).
- ram_org_din  in  16  original sample read data.
- ram_filt_din  in  16  filtered sample read data.
- pcm_thresh  out  16  PWM threshold for the current sample.
- sample_tick  out  1  pulse on the last clock of each PWM frame.
- busy  out  1  high in any state other than IDLE.
- state_o  out  2  encoded state: IDLE=0, FILTER=1, PRIME=2, PLAY=3.
- filt_err  out  1  sticky flag: filter timeout occurred.

Behaviour:
- Reset (async assert, sync release): state IDLE; ram_addr=0; pcm_thresh=0; frame counter=0; filt_start=0; sample_tick=0; busy=0; filt_err=0.
- IDLE, btn_start=1:
  - sw_play=1 → FILTER; filt_start pulses for exactly the one cycle of entry; filt_err cleared.
  - sw_play=0 → PRIME.
- FILTER: wait counter runs from 0.
  - filt_done=1 → PRIME.
  - Counter reaches FILT_TIMEOUT-1 without filt_done → IDLE, filt_err=1.
- PRIME: exactly one cycle; ram_addr=0, frame counter=0 → PLAY. Covers RAM read latency.
- PLAY, frame counter cnt runs 0..PWM_PERIOD-1:
  - cnt==1: pcm_thresh loads ram_filt_din if sw_play else ram_org_din. sw_play is sampled at that cycle, so a mid-run toggle takes effect at the next sample.
  - cnt==PWM_PERIOD-1: sample_tick=1 and cnt wraps to 0, then:
    - ram_addr<LAST_ADDR → ram_addr+1.
    - ram_addr==LAST_ADDR and sw_loop=1 → ram_addr=0, stay in PLAY.
    - ram_addr==LAST_ADDR and sw_loop=0 → IDLE, ram_addr=0, pcm_thresh=0.
- btn_stop in any non-IDLE state → IDLE next cycle; ram_addr=0, pcm_thresh=0, cnt=0, no sample_tick.
  - btn_stop wins over simultaneous btn_start, filt_done, or frame end.
  - Stop from FILTER does not abort the filter engine; a late filt_done in IDLE is ignored.
- btn_start while busy: ignored.
- filt_done outside FILTER: ignored.
- pcm_thresh holds its value between loads.
- Address arithmetic is unsigned ADDR_W with explicit wrap; no overflow past LAST_ADDR.
- Latency:
  - start → first valid pcm_thresh = 3 clocks (sw_play=0: IDLE→PRIME→PLAY cnt0→load at cnt1).
  - Output is registered the cycle after filt_done plus 3 when filtering.

Decomposition:
- Package audio_pkg:
  - state enum typedef play_state_t (IDLE, FILTER, PRIME, PLAY).
  - Localparams for default PWM_PERIOD and sample width 16.
  - Shared with the PWM stage and the filter engine.
- One natural sub-module: audio_frame_timer.
  - Holds the PWM_PERIOD frame counter.
  - Has clear/enable inputs and cnt, load_strobe (cnt==1) and sample_tick outputs.

Test Plan:
- sw_play=0, sw_loop=0, PWM_PERIOD=8, LAST_ADDR=3, RAM org[a]=16'h0100*(a+1); btn_start → ram_addr 0,1,2,3; pcm_thresh 0x0100,0x0200,0x0300,0x0400 loaded at cnt==1; 4 sample_ticks 8 clocks apart; returns to IDLE, busy=0.
- sw_play=1; btn_start → filt_start one-cycle pulse; filt_done after 20 clocks → PRIME then PLAY; pcm_thresh follows ram_filt_din.
- sw_play=1, FILT_TIMEOUT=16, filt_done never asserted → IDLE after 16 clocks in FILTER, filt_err=1; next btn_start clears filt_err.
- sw_loop=1, LAST_ADDR=3 → after addr 3, ram_addr wraps to 0 and state stays PLAY; btn_stop at cnt==7 of addr 2 → IDLE next cycle, no sample_tick, pcm_thresh=0.
- Same-cycle btn_start+btn_stop in PLAY → IDLE. btn_start in PLAY alone → no effect on addr or cnt. filt_done in IDLE → no state change.
- Assert rst mid-PLAY at addr 2, cnt 5 → all outputs are at reset values immediately, without a clock edge.
